multicycle_ctrl: RTL and testbench

Multi-cycle control sequencer for the RV32I-subset core. It replaces the single-cycle control unit when the core runs on a unified instruction/data memory behind a ready handshake. It sequences fetch, decode, execute, memory and writeback over several cycles, and drives every mux select and write enable of the shared ALU, register file, PC and instruction register. It also counts retired instructions and halts on an illegal opcode.

---
 rtl/lumos_mc_pkg.sv | 66 ++++++
 rtl/alu_decoder.sv | 48 ++++
 rtl/multicycle_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lumos_mc_pkg.sv
// ==========================================================================
// lumos_mc_pkg -- encodings shared by the multi-cycle controller and datapath
// Rev 1.0
// ==========================================================================
`default_nettype none

package lumos_mc_pkg;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECUTER = 4'd7,
    S_EXECUTEI = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  // ALU operation class handed from the FSM to the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD  = 2'b00,
    ALUOP_SUB  = 2'b01,
    ALUOP_FUNC = 2'b10
  } aluop_t;

  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_rtype  = 7'b0110011;
  localparam logic [6:0] c_op_itype  = 7'b0010011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;

  localparam logic [2:0] c_alu_add   = 3'b000;
  localparam logic [2:0] c_alu_sub   = 3'b001;
  localparam logic [2:0] c_alu_and   = 3'b010;
  localparam logic [2:0] c_alu_or    = 3'b011;
  localparam logic [2:0] c_alu_passb = 3'b100;
  localparam logic [2:0] c_alu_slt   = 3'b101;
  localparam logic [2:0] c_alu_xor   = 3'b110;
  localparam logic [2:0] c_alu_srl   = 3'b111;

  localparam logic [1:0] c_srca_pc    = 2'b00;
  localparam logic [1:0] c_srca_oldpc = 2'b01;
  localparam logic [1:0] c_srca_a     = 2'b10;

  localparam logic [1:0] c_srcb_b     = 2'b00;
  localparam logic [1:0] c_srcb_imm   = 2'b01;
  localparam logic [1:0] c_srcb_four  = 2'b10;

  localparam logic [1:0] c_res_aluout    = 2'b00;
  localparam logic [1:0] c_res_data      = 2'b01;
  localparam logic [1:0] c_res_aluresult = 2'b10;

  localparam logic [2:0] c_f3_beq = 3'b000;
  localparam logic [2:0] c_f3_bne = 3'b001;

endpackage

`default_nettype wire

// File: rtl/alu_decoder.sv
// ==========================================================================
// alu_decoder -- maps operation class and instruction fields to ALUControl
// Rev 1.0
// ==========================================================================
`default_nettype none

module alu_decoder
  import lumos_mc_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] func3_i,
  input  logic       func7_5_i,
  input  aluop_t     aluop_i,
  output logic [2:0] alu_control_o
);

  logic w_is_sub;

  // Only register-register adds honour IR[30]; addi immediates may set it freely
  assign w_is_sub = (opcode_i == c_op_rtype) && func7_5_i;

  always_comb begin
    alu_control_o = c_alu_add;
    case (aluop_i)
      ALUOP_ADD: alu_control_o = c_alu_add;
      ALUOP_SUB: alu_control_o = c_alu_sub;
      ALUOP_FUNC: begin
        if (opcode_i == c_op_lui) begin
          alu_control_o = c_alu_passb;
        end else begin
          case (func3_i)
            3'b000:  alu_control_o = w_is_sub ? c_alu_sub : c_alu_add;
            3'b010:  alu_control_o = c_alu_slt;
            3'b100:  alu_control_o = c_alu_xor;
            3'b101:  alu_control_o = c_alu_srl;
            3'b110:  alu_control_o = c_alu_or;
            3'b111:  alu_control_o = c_alu_and;
            default: alu_control_o = c_alu_add;
          endcase
        end
      end
      default: alu_control_o = c_alu_add;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ==========================================================================
// multicycle_ctrl -- multi-cycle fetch/decode/execute sequencer, retire count
// Rev 1.0
// ==========================================================================
`default_nettype none

module multicycle_ctrl
  import lumos_mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  func3,
  input  logic        func7_5,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_valid,
  output logic        mem_we,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [2:0]  ALUControl,
  output logic [31:0] retired,
  output logic        illegal
);

  state_t      state_q;
  state_t      state_d;
  logic [31:0] retired_q;
  logic [31:0] retired_d;
  aluop_t      w_aluop;
  logic        w_retire;
  logic [2:0]  w_alu_control;

  alu_decoder u_alu_decoder (
    .opcode_i      (opcode),
    .func3_i       (func3),
    .func7_5_i     (func7_5),
    .aluop_i       (w_aluop),
    .alu_control_o (w_alu_control)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_RESET;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign retired_d  = retired_q + {31'd0, w_retire};
  assign retired    = retired_q;
  assign ALUControl = w_alu_control;

  always_comb begin
    state_d   = state_q;
    w_retire  = 1'b0;
    w_aluop   = ALUOP_ADD;
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = c_srca_pc;
    ALUSrcB   = c_srcb_b;
    ResultSrc = c_res_aluout;
    illegal   = 1'b0;

    case (state_q)
      S_RESET: state_d = S_FETCH;

      // PC+4 is computed and written straight through ALUResult
      S_FETCH: begin
        mem_valid = 1'b1;
        ALUSrcA   = c_srca_pc;
        ALUSrcB   = c_srcb_four;
        ResultSrc = c_res_aluresult;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        ALUSrcA = c_srca_oldpc;
        ALUSrcB = c_srcb_imm;
        case (opcode)
          c_op_load, c_op_store: state_d = S_MEMADR;
          c_op_rtype:            state_d = S_EXECUTER;
          c_op_itype, c_op_lui:  state_d = S_EXECUTEI;
          c_op_branch:           state_d = S_BRANCH;
          c_op_jal:              state_d = S_JAL;
          default:               state_d = S_TRAP;
        endcase
      end

      S_MEMADR: begin
        ALUSrcA = c_srca_a;
        ALUSrcB = c_srcb_imm;
        state_d = (opcode == c_op_load) ? S_MEMREAD : S_MEMWRITE;
      end

      S_MEMREAD: begin
        mem_valid = 1'b1;
        AdrSrc    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end

      S_MEMWB: begin
        ResultSrc = c_res_data;
        RegWrite  = 1'b1;
        w_retire  = 1'b1;
        state_d   = S_FETCH;
      end

      S_MEMWRITE: begin
        mem_valid = 1'b1;
        mem_we    = 1'b1;
        AdrSrc    = 1'b1;
        if (mem_ready) begin
          w_retire = 1'b1;
          state_d  = S_FETCH;
        end
      end

      S_EXECUTER: begin
        ALUSrcA = c_srca_a;
        ALUSrcB = c_srcb_b;
        w_aluop = ALUOP_FUNC;
        state_d = S_ALUWB;
      end

      S_EXECUTEI: begin
        ALUSrcA = c_srca_a;
        ALUSrcB = c_srcb_imm;
        w_aluop = ALUOP_FUNC;
        state_d = S_ALUWB;
      end

      S_ALUWB: begin
        ResultSrc = c_res_aluout;
        RegWrite  = 1'b1;
        w_retire  = 1'b1;
        state_d   = S_FETCH;
      end

      // ALUOut still holds the DECODE-computed target during the compare
      S_BRANCH: begin
        ALUSrcA   = c_srca_a;
        ALUSrcB   = c_srcb_b;
        w_aluop   = ALUOP_SUB;
        ResultSrc = c_res_aluout;
        PCWrite   = ((func3 == c_f3_beq) && zero) || ((func3 == c_f3_bne) && !zero);
        w_retire  = 1'b1;
        state_d   = S_FETCH;
      end

      S_JAL: begin
        ALUSrcA   = c_srca_oldpc;
        ALUSrcB   = c_srcb_four;
        ResultSrc = c_res_aluout;
        PCWrite   = 1'b1;
        state_d   = S_ALUWB;
      end

      S_TRAP: illegal = 1'b1;

      default: state_d = S_RESET;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ==========================================================================
// tb_multicycle_ctrl -- scoreboard bench for the multi-cycle controller
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_multicycle_ctrl;

  logic        clk;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic        func7_5;
  logic        zero;
  logic        mem_ready;
  logic        mem_valid;
  logic        mem_we;
  logic        AdrSrc;
  logic        IRWrite;
  logic        PCWrite;
  logic        RegWrite;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic [2:0]  ALUControl;
  logic [31:0] retired;
  logic        illegal;

  multicycle_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .func3      (func3),
    .func7_5    (func7_5),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_valid  (mem_valid),
    .mem_we     (mem_we),
    .AdrSrc     (AdrSrc),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ALUControl (ALUControl),
    .retired    (retired),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word: mv, we, AdrSrc, IRWrite, PCWrite, RegWrite, SrcA, SrcB, ResultSrc, ALUControl, illegal
  function automatic logic [15:0] mk(input logic mv, input logic we, input logic adr,
                                     input logic irw, input logic pcw, input logic rw,
                                     input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] res, input logic [2:0] alu,
                                     input logic ill);
    return {mv, we, adr, irw, pcw, rw, a, b, res, alu, ill};
  endfunction

  localparam logic [15:0] E_Z       = 16'h0000;
  localparam logic [15:0] E_FETCH_W = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10, 3'b000, 1'b0);
  localparam logic [15:0] E_FETCH_R = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 2'b10, 3'b000, 1'b0);
  localparam logic [15:0] E_DECODE  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 3'b000, 1'b0);
  localparam logic [15:0] E_MEMADR  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0);
  localparam logic [15:0] E_MEMRD   = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);
  localparam logic [15:0] E_MEMWB   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0);
  localparam logic [15:0] E_MEMWR   = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);
  localparam logic [15:0] E_ALUWB   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);
  localparam logic [15:0] E_JAL     = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b10, 2'b00, 3'b000, 1'b0);
  localparam logic [15:0] E_TRAP    = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1);

  function automatic logic [15:0] e_exr(input logic [2:0] alu);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, alu, 1'b0);
  endfunction
  function automatic logic [15:0] e_exi(input logic [2:0] alu);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, alu, 1'b0);
  endfunction
  function automatic logic [15:0] e_br(input logic pcw);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, pcw, 1'b0, 2'b10, 2'b00, 2'b00, 3'b001, 1'b0);
  endfunction

  logic [15:0] cq[$];
  logic [31:0] rq[$];
  string       nq[$];
  logic [31:0] exp_ret;
  logic        mon_en;
  int          n_checks;
  int          n_pass;

  // Monitor: every enabled cycle the DUT presents a control word that must match the next entry
  always @(negedge clk) begin
    if (mon_en) begin
      logic [15:0] act;
      logic [15:0] c;
      logic [31:0] r;
      string       nm;
      act = {mem_valid, mem_we, AdrSrc, IRWrite, PCWrite, RegWrite,
             ALUSrcA, ALUSrcB, ResultSrc, ALUControl, illegal};
      n_checks++;
      if (cq.size() == 0) begin
        $display("FAIL scoreboard_empty: ctl=%h retired=%h with no expected entry", act, retired);
      end else begin
        c  = cq.pop_front();
        r  = rq.pop_front();
        nm = nq.pop_front();
        if (act !== c || retired !== r)
          $display("FAIL %s @%0t: ctl=%h retired=%h, expected ctl=%h retired=%h",
                   nm, $time, act, retired, c, r);
        else
          n_pass++;
      end
    end
  end

  task automatic set_ir(input logic [31:0] ir);
    opcode  = ir[6:0];
    func3   = ir[14:12];
    func7_5 = ir[30];
  endtask

  // One clock cycle: drive inputs, queue the expected response, advance to posedge+1
  task automatic step(input logic rdy, input logic zr, input logic [15:0] c,
                      input bit inc, input string nm);
    mem_ready = rdy;
    zero      = zr;
    cq.push_back(c);
    rq.push_back(exp_ret);
    nq.push_back(nm);
    if (inc) exp_ret = exp_ret + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_fetch(input logic [31:0] ir, input int waits);
    set_ir(ir);
    for (int i = 0; i < waits; i++) step(1'b0, 1'b0, E_FETCH_W, 1'b0, "fetch_wait");
    step(1'b1, 1'b0, E_FETCH_R, 1'b0, "fetch");
  endtask

  task automatic alu_instr(input logic [31:0] ir, input bit is_r, input logic [2:0] alu,
                           input string nm);
    run_fetch(ir, 0);
    step(1'b1, 1'b0, E_DECODE, 1'b0, "decode");
    step(1'b1, 1'b1, is_r ? e_exr(alu) : e_exi(alu), 1'b0, nm);
    step(1'b1, 1'b0, E_ALUWB, 1'b1, "aluwb");
  endtask

  initial begin
    rst = 1'b0; mem_ready = 1'b0; zero = 1'b0;
    opcode = 7'd0; func3 = 3'd0; func7_5 = 1'b0;
    exp_ret = 32'd0; mon_en = 1'b0; n_checks = 0; n_pass = 0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;

    step(1'b1, 1'b0, E_Z, 1'b0, "in_reset");
    rst = 1'b1;
    step(1'b1, 1'b0, E_Z, 1'b0, "reset_state");

    alu_instr(32'h0050_0093, 1'b0, 3'b000, "addi_exec");

    run_fetch(32'h4020_8133, 3);
    step(1'b1, 1'b0, E_DECODE, 1'b0, "decode");
    step(1'b1, 1'b0, e_exr(3'b001), 1'b0, "sub_exec");
    step(1'b1, 1'b0, E_ALUWB, 1'b1, "aluwb");

    run_fetch(32'h0000_A183, 0);
    step(1'b1, 1'b0, E_DECODE, 1'b0, "decode");
    step(1'b1, 1'b0, E_MEMADR, 1'b0, "lw_memadr");
    step(1'b0, 1'b0, E_MEMRD, 1'b0, "memread_wait");
    step(1'b0, 1'b0, E_MEMRD, 1'b0, "memread_wait");
    step(1'b1, 1'b0, E_MEMRD, 1'b0, "memread_done");
    step(1'b1, 1'b0, E_MEMWB, 1'b1, "memwb");

    run_fetch(32'h0030_A223, 0);
    step(1'b1, 1'b0, E_DECODE, 1'b0, "decode");
    step(1'b1, 1'b0, E_MEMADR, 1'b0, "sw_memadr");
    step(1'b0, 1'b0, E_MEMWR, 1'b0, "memwrite_wait");
    step(1'b0, 1'b0, E_MEMWR, 1'b0, "memwrite_wait");
    step(1'b1, 1'b0, E_MEMWR, 1'b1, "memwrite_done");

    run_fetch(32'h0020_8463, 0);
    step(1'b1, 1'b1, E_DECODE, 1'b0, "decode");
    step(1'b1, 1'b1, e_br(1'b1), 1'b1, "beq_taken");
    run_fetch(32'h0020_9463, 0);
    step(1'b1, 1'b1, E_DECODE, 1'b0, "decode");
    step(1'b1, 1'b1, e_br(1'b0), 1'b1, "bne_not_taken");
    run_fetch(32'h0020_9463, 0);
    step(1'b1, 1'b0, E_DECODE, 1'b0, "decode");
    step(1'b1, 1'b0, e_br(1'b1), 1'b1, "bne_taken");

    alu_instr(32'h0FF0_E093, 1'b0, 3'b011, "ori_exec");
    alu_instr(32'h0FF0_C093, 1'b0, 3'b110, "xori_exec");
    alu_instr(32'hC000_0093, 1'b0, 3'b000, "addi_bit30_exec");
    alu_instr(32'h1234_5037, 1'b0, 3'b100, "lui_exec");
    alu_instr(32'h0020_A1B3, 1'b1, 3'b101, "slt_exec");
    alu_instr(32'h0020_D1B3, 1'b1, 3'b111, "srl_exec");
    alu_instr(32'h0020_F1B3, 1'b1, 3'b010, "and_exec");
    alu_instr(32'h0020_91B3, 1'b1, 3'b000, "sll_unmapped_exec");

    run_fetch(32'h0080_00EF, 0);
    step(1'b1, 1'b0, E_DECODE, 1'b0, "decode");
    step(1'b1, 1'b0, E_JAL, 1'b0, "jal");
    step(1'b1, 1'b0, E_ALUWB, 1'b1, "jal_aluwb");

    run_fetch(32'h0000_A183, 0);
    step(1'b1, 1'b0, E_DECODE, 1'b0, "decode");
    step(1'b1, 1'b0, E_MEMADR, 1'b0, "lw_memadr");
    step(1'b0, 1'b0, E_MEMRD, 1'b0, "memread_wait");
    rst = 1'b0;
    exp_ret = 32'd0;
    step(1'b0, 1'b0, E_Z, 1'b0, "async_reset");
    step(1'b1, 1'b0, E_Z, 1'b0, "reset_held");
    rst = 1'b1;
    step(1'b1, 1'b0, E_Z, 1'b0, "restart_reset");
    alu_instr(32'h0050_0093, 1'b0, 3'b000, "restart_addi");

    set_ir(32'h0050_0093);
    force dut.retired_q = 32'hFFFF_FFFF;
    exp_ret = 32'hFFFF_FFFF;
    step(1'b0, 1'b0, E_FETCH_W, 1'b0, "preload");
    release dut.retired_q;
    step(1'b1, 1'b0, E_FETCH_R, 1'b0, "fetch");
    step(1'b1, 1'b0, E_DECODE, 1'b0, "decode");
    step(1'b1, 1'b0, e_exi(3'b000), 1'b0, "addi_exec");
    step(1'b1, 1'b0, E_ALUWB, 1'b1, "wrap_aluwb");
    step(1'b0, 1'b0, E_FETCH_W, 1'b0, "wrapped");

    run_fetch(32'h0000_007F, 0);
    step(1'b1, 1'b0, E_DECODE, 1'b0, "decode");
    for (int i = 0; i < 5; i++) begin
      logic b;
      b = (i % 2) == 0;
      step(b, b, E_TRAP, 1'b0, "trap");
    end

    mon_en = 1'b0;
    n_checks++;
    if (cq.size() != 0)
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", cq.size());
    else
      n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
